// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: serialises functional-unit results into one registered CDB slot.
// Define CDB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cdb_arbiter #(
    parameter int NumUnits      = 4,
    parameter int DatapathWidth = 32,
    parameter int TagWidth      = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumUnits-1:0]               unit_valid_i,
    output logic [NumUnits-1:0]               unit_ready_o,
    input  logic [NumUnits*TagWidth-1:0]      unit_tag_i,
    input  logic [NumUnits*DatapathWidth-1:0] unit_result_i,
    input  logic [NumUnits-1:0]               unit_branch_taken_i,
    output logic                              cdb_valid_o,
    input  logic                              cdb_ready_i,
    output logic [TagWidth-1:0]               cdb_tag_o,
    output logic [DatapathWidth-1:0]          cdb_result_o,
    output logic                              cdb_branch_taken_o,
    output logic [$clog2(NumUnits)-1:0]       cdb_unit_o
);

    localparam int IdxW = $clog2(NumUnits);

    logic                     cdb_valid_q, cdb_valid_d;
    logic [TagWidth-1:0]      cdb_tag_q, cdb_tag_d;
    logic [DatapathWidth-1:0] cdb_result_q, cdb_result_d;
    logic                     cdb_bt_q, cdb_bt_d;
    logic [IdxW-1:0]          cdb_unit_q, cdb_unit_d;

    logic            load_en;
    logic            gnt_found;
    logic [IdxW-1:0] gnt_idx;
    int              search_base;

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign search_base = 0;
`else
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

    assign search_base = int'(rr_ptr_q);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load_en && gnt_found) begin
            rr_ptr_d = (gnt_idx == IdxW'(NumUnits - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // The pointer only advances on a grant, so a stalled unit keeps its turn.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign load_en = !cdb_valid_q || cdb_ready_i;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NumUnits; k++) begin
            int              cand;
            logic [IdxW-1:0] cand_idx;
            cand = search_base + k;
            if (cand >= NumUnits) begin
                cand = cand - NumUnits;
            end
            cand_idx = IdxW'(cand);
            if (!gnt_found && unit_valid_i[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        unit_ready_o = '0;
        if (rst_ni && load_en && gnt_found) begin
            unit_ready_o = NumUnits'(1) << gnt_idx;
        end
    end

    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_tag_d    = cdb_tag_q;
        cdb_result_d = cdb_result_q;
        cdb_bt_d     = cdb_bt_q;
        cdb_unit_d   = cdb_unit_q;
        if (load_en) begin
            cdb_valid_d = gnt_found;
            if (gnt_found) begin
                cdb_tag_d    = unit_tag_i[gnt_idx*TagWidth +: TagWidth];
                cdb_result_d = unit_result_i[gnt_idx*DatapathWidth +: DatapathWidth];
                cdb_bt_d     = unit_branch_taken_i[gnt_idx];
                cdb_unit_d   = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_result_q <= '0;
            cdb_bt_q     <= 1'b0;
            cdb_unit_q   <= '0;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_result_q <= cdb_result_d;
            cdb_bt_q     <= cdb_bt_d;
            cdb_unit_q   <= cdb_unit_d;
        end
    end

    assign cdb_valid_o        = cdb_valid_q;
    assign cdb_tag_o          = cdb_tag_q;
    assign cdb_result_o       = cdb_result_q;
    assign cdb_branch_taken_o = cdb_bt_q;
    assign cdb_unit_o         = cdb_unit_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised bench for cdb_arbiter against a transaction-level model of the CDB slot.
// Directed sequences cover reset, wrap-around, stall hold and async reset discard.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [N-1:0]      unit_valid_i;
    logic [N-1:0]      unit_ready_o;
    logic [N*TW-1:0]   unit_tag_i;
    logic [N*DW-1:0]   unit_result_i;
    logic [N-1:0]      unit_branch_taken_i;
    logic              cdb_valid_o;
    logic              cdb_ready_i;
    logic [TW-1:0]     cdb_tag_o;
    logic [DW-1:0]     cdb_result_o;
    logic              cdb_branch_taken_o;
    logic [1:0]        cdb_unit_o;

    cdb_arbiter #(.NumUnits(N), .DatapathWidth(DW), .TagWidth(TW)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .unit_valid_i        (unit_valid_i),
        .unit_ready_o        (unit_ready_o),
        .unit_tag_i          (unit_tag_i),
        .unit_result_i       (unit_result_i),
        .unit_branch_taken_i (unit_branch_taken_i),
        .cdb_valid_o         (cdb_valid_o),
        .cdb_ready_i         (cdb_ready_i),
        .cdb_tag_o           (cdb_tag_o),
        .cdb_result_o        (cdb_result_o),
        .cdb_branch_taken_o  (cdb_branch_taken_o),
        .cdb_unit_o          (cdb_unit_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Pending result held by each unit
    bit            u_v   [N];
    logic [TW-1:0] u_tag [N];
    logic [DW-1:0] u_res [N];
    bit            u_bt  [N];

    // Reference CDB slot and fairness bookkeeping
    bit            m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_res;
    bit            m_bt;
    int            m_unit;
    int            m_ptr;
    int            m_wait [N];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            unit_valid_i[i]           = u_v[i];
            unit_tag_i[i*TW +: TW]    = u_tag[i];
            unit_result_i[i*DW +: DW] = u_res[i];
            unit_branch_taken_i[i]    = u_bt[i];
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_tag   = '0;
        m_res   = '0;
        m_bt    = 0;
        m_unit  = 0;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int u;
`ifdef CDB_ARB_FIXED_PRIO_EN
            u = k;
`else
            u = (m_ptr + k) % N;
`endif
            if (u_v[u]) return u;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        check("cdb_valid", 64'(cdb_valid_o), 64'(m_valid));
        check("cdb_tag", 64'(cdb_tag_o), 64'(m_tag));
        check("cdb_result", 64'(cdb_result_o), 64'(m_res));
        check("cdb_bt", 64'(cdb_branch_taken_o), 64'(m_bt));
        check("cdb_unit", 64'(cdb_unit_o), 64'(m_unit));
    endtask

    // One clock: predict the grant, check ready, advance model, check the slot.
    task automatic step(input bit rnd);
        bit           load;
        int           g;
        logic [N-1:0] exp_rdy;
        @(negedge clk_i);
        load    = !m_valid || cdb_ready_i;
        g       = load ? pick() : -1;
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        check("unit_ready", 64'(unit_ready_o), 64'(exp_rdy));
        if (g >= 0) begin
`ifndef CDB_ARB_FIXED_PRIO_EN
            check("starve_bound", 64'(m_wait[g] < N), 64'd1);
            for (int i = 0; i < N; i++) if (u_v[i] && i != g) m_wait[i]++;
            m_wait[g] = 0;
`endif
            m_valid = 1;
            m_tag   = u_tag[g];
            m_res   = u_res[g];
            m_bt    = u_bt[g];
            m_unit  = g;
            m_ptr   = (g + 1) % N;
        end else if (load) begin
            m_valid = 0;
        end
        @(posedge clk_i);
        #1;
        check_outputs();
        if (g >= 0) u_v[g] = 0;
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                if (!u_v[i] && ($urandom % 2 == 0)) begin
                    u_v[i]   = 1;
                    u_tag[i] = TW'($urandom);
                    u_res[i] = $urandom;
                    u_bt[i]  = 1'($urandom);
                end
            end
            cdb_ready_i = ($urandom % 4) != 0;
        end
        apply();
    endtask

    // Asynchronous reset mid-cycle; release lands after an edge so no edge goes unmodelled.
    task automatic do_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 64'(cdb_valid_o), 64'd0);
        check("rst_ready", 64'(unit_ready_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        check_outputs();
        rst_ni = 1'b1;
    endtask

    task automatic set_unit(input int i, input logic [TW-1:0] t,
                            input logic [DW-1:0] r, input bit b);
        u_v[i]   = 1;
        u_tag[i] = t;
        u_res[i] = r;
        u_bt[i]  = b;
    endtask

    initial begin
        rst_ni      = 1'b0;
        cdb_ready_i = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) set_unit(i, TW'(i + 8), 32'h1000 * (i + 1), 1'(i));
        apply();
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_valid", 64'(cdb_valid_o), 64'd0);
        check_outputs();
        rst_ni = 1'b1;

        // All four valid with ready high: rotation 0,1,2,3 then a refilled unit 0
        for (int c = 0; c < 5; c++) begin
            step(0);
            if (c == 3) set_unit(0, 4'hc, 32'h5555_0000, 1'b1);
            apply();
        end

        // Stall hold on unit 2's result while unit 0 waits
        do_reset();
        for (int i = 0; i < N; i++) u_v[i] = 0;
        set_unit(2, 4'd5, 32'hDEADBEEF, 1'b1);
        cdb_ready_i = 1'b0;
        apply();
        step(0);
        set_unit(0, 4'd3, 32'h0000_1234, 1'b0);
        apply();
        repeat (3) step(0);
        cdb_ready_i = 1'b1;
        apply();
        step(0);
        step(0);

        // Wrap from unit 3 back to unit 0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_unit(i, TW'(i), DW'(i * 7), 1'b0);
            apply();
            step(0);
        end
        set_unit(3, 4'd9, 32'hCAFE_0003, 1'b1);
        apply();
        step(0);
        set_unit(0, 4'd1, 32'hCAFE_0000, 1'b0);
        set_unit(3, 4'd2, 32'hCAFE_0013, 1'b0);
        apply();
        step(0);
        step(0);

        // Reset while a stalled slot is valid
        cdb_ready_i = 1'b0;
        set_unit(1, 4'd6, 32'h0BAD_F00D, 1'b1);
        apply();
        step(0);
        step(0);
        do_reset();
        cdb_ready_i = 1'b1;
        apply();

        for (int c = 0; c < 400; c++) begin
            step(1);
            if ($urandom % 100 == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
